// File: rtl/grf_mp_if.sv
// Register-file access bundle: two write ports, three read ports with busy
// bits, the issue/claim port and the write-collision flag.
interface grf_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          bsy0;
    logic          bsy1;
    logic          bsy2;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          wcol;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, ra2, iss_en, iss_addr,
        input  rd0, rd1, rd2, bsy0, bsy1, bsy2, wcol
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, ra2, iss_en, iss_addr,
        output rd0, rd1, rd2, bsy0, bsy1, bsy2, wcol
    );
endinterface

// File: rtl/grf_mp.sv
// Multi-port register file: 3 async reads, 2 prioritised sync writes,
// optional write-to-read bypass and a per-register busy scoreboard.
module grf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic   clk,
    input logic   reset,
    grf_mp_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wcol_q;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             iss_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    // Port 1 is checked first so it wins both the bypass and the storage race.
    function automatic logic [DW-1:0] read_port(
        input logic          rst,
        input logic [AW-1:0] a,
        input logic [DW-1:0] stored,
        input logic          w0,
        input logic [AW-1:0] a0,
        input logic [DW-1:0] d0,
        input logic          w1,
        input logic [AW-1:0] a1,
        input logic [DW-1:0] d1
    );
        if (rst || !addr_ok(a))
            return '0;
        if (BYPASS != 0 && w1 && a1 == a)
            return d1;
        if (BYPASS != 0 && w0 && a0 == a)
            return d0;
        return stored;
    endfunction

    function automatic logic busy_port(
        input logic          rst,
        input logic [AW-1:0] a,
        input logic          stored
    );
        return !rst && addr_ok(a) && stored;
    endfunction

    assign wr0_ok = bus.we0 && addr_ok(bus.wa0);
    assign wr1_ok = bus.we1 && addr_ok(bus.wa1);
    assign iss_ok = bus.iss_en && addr_ok(bus.iss_addr);

    // Clears applied before the set so a new producer claiming the
    // register being written keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok)
            busy_nxt[bus.wa0] = 1'b0;
        if (wr1_ok)
            busy_nxt[bus.wa1] = 1'b0;
        if (iss_ok)
            busy_nxt[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy   <= '0;
            wcol_q <= 1'b0;
        end else begin
            if (wr0_ok)
                regs[bus.wa0] <= bus.wd0;
            if (wr1_ok)
                regs[bus.wa1] <= bus.wd1;
            busy   <= busy_nxt;
            wcol_q <= bus.we0 && bus.we1 && (bus.wa0 == bus.wa1);
        end
    end

    assign bus.rd0 = read_port(reset, bus.ra0, regs[bus.ra0], bus.we0, bus.wa0, bus.wd0,
                               bus.we1, bus.wa1, bus.wd1);
    assign bus.rd1 = read_port(reset, bus.ra1, regs[bus.ra1], bus.we0, bus.wa0, bus.wd0,
                               bus.we1, bus.wa1, bus.wd1);
    assign bus.rd2 = read_port(reset, bus.ra2, regs[bus.ra2], bus.we0, bus.wa0, bus.wd0,
                               bus.we1, bus.wa1, bus.wd1);

    assign bus.bsy0 = busy_port(reset, bus.ra0, busy[bus.ra0]);
    assign bus.bsy1 = busy_port(reset, bus.ra1, busy[bus.ra1]);
    assign bus.bsy2 = busy_port(reset, bus.ra2, busy[bus.ra2]);

    assign bus.wcol = wcol_q;
endmodule
